// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the register write arbiter.
// REG_ARB_LOCK_EN adds the LOCKED state for multi-cycle exclusive ownership.
package reg_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 4;

`ifdef REG_ARB_LOCK_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1
  } arb_state_e;
`endif

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr,
// wrapping from NREQ-1 back to 0.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int PW  = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   win_idx,
  output logic            vld
);

  int cand;

  always_comb begin
    win     = '0;
    win_idx = '0;
    vld     = 1'b0;
    cand    = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!vld && req[cand]) begin
        vld       = 1'b1;
        win_idx   = PW'(cand);
        win[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter sharing one register write port among NREQ requesters.
// Optional REG_ARB_LOCK_EN: lock input lets a winner hold the port over several writes.
module reg_wr_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0][DW-1:0]  wr_data,
`ifdef REG_ARB_LOCK_EN
  input  logic [NREQ-1:0]          lock,
`endif
  output logic [NREQ-1:0]          gnt,
  output logic                     reg_we,
  output logic [DW-1:0]            reg_wdata,
  output logic                     busy
);

  localparam int PW = idx_w(NREQ);

  arb_state_e      state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic            we_nxt;
  logic [DW-1:0]   wdata_nxt;

  logic [NREQ-1:0] pick_win;
  logic [PW-1:0]   pick_idx;
  logic            pick_vld;

`ifdef REG_ARB_LOCK_EN
  logic [PW-1:0]   owner, owner_nxt;
`endif

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + PW'(1);
  endfunction

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win     (pick_win),
    .win_idx (pick_idx),
    .vld     (pick_vld)
  );

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = '0;
    we_nxt    = 1'b0;
    wdata_nxt = reg_wdata;
`ifdef REG_ARB_LOCK_EN
    owner_nxt = owner;
`endif
    case (state)
      IDLE: begin
        if (pick_vld) begin
          gnt_nxt   = pick_win;
          we_nxt    = 1'b1;
          wdata_nxt = wr_data[pick_idx];
          ptr_nxt   = next_ptr(pick_idx);
          state_nxt = GRANT;
`ifdef REG_ARB_LOCK_EN
          if (lock[pick_idx]) begin
            state_nxt = LOCKED;
            owner_nxt = pick_idx;
          end
`endif
        end
      end
      GRANT: state_nxt = IDLE;
`ifdef REG_ARB_LOCK_EN
      // Owner keeps the port; a write issues only on edges where it still requests.
      LOCKED: begin
        if (!lock[owner]) begin
          state_nxt = IDLE;
          ptr_nxt   = next_ptr(owner);
        end else if (req[owner]) begin
          gnt_nxt[owner] = 1'b1;
          we_nxt         = 1'b1;
          wdata_nxt      = wr_data[owner];
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      reg_we    <= 1'b0;
      reg_wdata <= '0;
`ifdef REG_ARB_LOCK_EN
      owner     <= '0;
`endif
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt       <= gnt_nxt;
      reg_we    <= we_nxt;
      reg_wdata <= wdata_nxt;
`ifdef REG_ARB_LOCK_EN
      owner     <= owner_nxt;
`endif
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/reg_wr_arbiter.md
REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one register write port.
REQ-002 Parameter DW, default 4, register data width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req  input  NREQ  per-requester write request; held until its gnt bit is seen.
REQ-006 wr_data  input  NREQ x DW  per-requester write data; stable while its req is high.
REQ-007 lock  input  NREQ  per-requester lock request; present only with REG_ARB_LOCK_EN.
REQ-008 gnt  output  NREQ  one-hot grant; the granted requester's write occurs in the same cycle.
REQ-009 reg_we  output  1  write enable to the shared register.
REQ-010 reg_wdata  output  DW  write data to the shared register.
REQ-011 busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 All outputs SHALL be registered; gnt, reg_we and reg_wdata in cycle k+1 reflect inputs sampled at the edge ending cycle k.
REQ-013 FSM states SHALL be IDLE and GRANT, plus LOCKED with REG_ARB_LOCK_EN.
REQ-014 IDLE with any req high SHALL select one winner w, go to GRANT, set gnt[w]=1, reg_we=1, reg_wdata=wr_data[w].
REQ-015 IDLE with no req SHALL stay IDLE with gnt=0, reg_we=0, reg_wdata holding its last value.
REQ-016 GRANT SHALL last exactly one cycle and return to IDLE; no arbitration occurs during GRANT.
REQ-017 Max throughput SHALL be one write per two cycles; a single request has one-cycle latency.
REQ-018 Winner selection SHALL be round-robin: scan from pointer ptr upward, wrapping NREQ-1 to 0.
REQ-019 After a grant to w, ptr SHALL become (w+1) mod NREQ; ptr is unchanged when no grant issues.
REQ-020 gnt SHALL never have more than one bit set; reg_we SHALL equal OR of gnt.
REQ-021 A req still high in the IDLE cycle after its grant SHALL be treated as a new request.

Reset
REQ-022 rst high at an edge SHALL force state IDLE, ptr=0, gnt=0, reg_we=0, reg_wdata=0, busy=0 in the next cycle, regardless of state.
REQ-023 rst during GRANT or LOCKED SHALL abort: no write in the cycle following the reset edge.
REQ-024 rst SHALL take priority over all requests sampled at the same edge.

Configuration
REQ-025 Macro REG_ARB_LOCK_EN SHALL compile in the lock input and LOCKED state.
REQ-026 With REG_ARB_LOCK_EN, a grant to w with lock[w] high SHALL enter LOCKED instead of GRANT, owner=w.
REQ-027 In LOCKED, gnt[owner] and reg_we SHALL be high in each cycle following an edge where req[owner] was high, reg_wdata=wr_data[owner]; other requests are ignored.
REQ-028 LOCKED SHALL exit to IDLE after an edge sampling lock[owner] low, with no write in that next cycle; ptr=(owner+1) mod NREQ.
REQ-029 Without REG_ARB_LOCK_EN, no lock port exists and behaviour is REQ-013..021 only.

Structure
REQ-030 Package reg_arb_pkg SHALL hold the state enum and default NREQ/DW constants.
REQ-031 Sub-module rr_pick SHALL implement the combinational round-robin winner selection (req, ptr -> one-hot winner, valid).

Verification
REQ-032 rst high 2 cycles -> gnt=0, reg_we=0, reg_wdata=0, busy=0 throughout and after.
REQ-033 req=4'b0100, wr_data[2]=4'hA -> next cycle gnt=4'b0100, reg_we=1, reg_wdata=4'hA for exactly one cycle; busy=1 that cycle.
REQ-034 All req high from reset, wr_data=1,2,3,4, each req dropped after its gnt -> grants 0,1,2,3 on alternate cycles, reg_wdata 1,2,3,4.
REQ-035 After grant to 3, req[0] and req[3] both high -> req 0 granted first, then 3.
REQ-036 rst asserted at the edge ending a GRANT cycle -> next cycle reg_we=0, gnt=0; subsequent req[1],req[2] together grants 1 first (ptr=0 after reset).
REQ-037 REG_ARB_LOCK_EN: req[1], lock[1] high, wr_data[1] stepping 5,6,7 over 3 cycles while req[0] high -> three consecutive writes 5,6,7 with gnt=4'b0010; lock[1] low -> IDLE, then req 0 granted.
